csr_ctrl: RTL and testbench

Multi-cycle sequencer that initiates every access to the machine-mode CSR register file. It accepts one decoded SYSTEM instruction at a time from decode: csrrw/csrrs/csrrc and their immediate forms, ecall, or mret. It drives the CSR file's read address, write strobe, and ecall/mret trap pulses, then hands the rd write-back value and any PC redirect to write-back. It sits between the decode stage and the CSR register file in the multi-cycle core.

---
 rtl/csr_ctrl_pkg.sv | 17 +
 rtl/csr_ctrl_alu.sv | 19 +
 rtl/csr_ctrl.sv | 102 ++++++++++
 tb/tb_csr_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/csr_ctrl_pkg.sv
// csr_ctrl_pkg: shared constants, funct3 encodings and FSM states for the CSR sequencer
package csr_ctrl_pkg;
    localparam int XLEN        = 32;
    localparam int ECALL_CAUSE = 11;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [2:0] F3_PRIV   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
endpackage

// File: rtl/csr_ctrl_alu.sv
// csr_ctrl_alu: new CSR value and write-needed flag for csrrw/s/c and immediate forms
module csr_alu #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [4:0]      zimm_i,
    output logic [XLEN-1:0] new_o,
    output logic            we_o
);
    logic [XLEN-1:0] src;
    logic [1:0]      op;
    assign op    = funct3_i[1:0];
    assign src   = funct3_i[2] ? {{(XLEN-5){1'b0}}, zimm_i} : src1_i;
    assign new_o = op == 2'b01 ? src : op == 2'b10 ? (old_i | src) : op == 2'b11 ? (old_i & ~src) : old_i;
    // set/clear with rs1/uimm field zero must not write (no side effects on read-only CSRs)
    assign we_o  = op == 2'b01 || (op != 2'b00 && zimm_i != 5'd0);
endmodule

// File: rtl/csr_ctrl.sv
// csr_ctrl: multi-cycle sequencer driving CSR file reads, writes and ecall/mret traps
module csr_ctrl #(
    parameter int XLEN        = 32,
    parameter int ECALL_CAUSE = 11
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [4:0]      zimm_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            is_ecall_i,
    input  logic            is_mret_i,
    output logic [11:0]     csr_addr_o,
    input  logic [XLEN-1:0] csr_rdata_i,
    output logic            csr_we_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            trap_ecall_o,
    output logic            trap_mret_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [4:0]      rd_o,
    output logic            rd_we_o,
    output logic [XLEN-1:0] rd_wdata_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o
);
    import csr_ctrl_pkg::*;
    state_e          state_q, state_d;
    logic [2:0]      funct3_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] src1_q, pc_q, old_q, alu_new;
    logic [4:0]      zimm_q, rd_q;
    logic            ecall_q, mret_q, trap, alu_we, in_write;
    csr_alu #(.XLEN(XLEN)) u_alu (
        .funct3_i (funct3_q),
        .old_i    (old_q),
        .src1_i   (src1_q),
        .zimm_i   (zimm_q),
        .new_o    (alu_new),
        .we_o     (alu_we)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            funct3_q <= '0;
            addr_q   <= '0;
            src1_q   <= '0;
            zimm_q   <= '0;
            rd_q     <= '0;
            pc_q     <= '0;
            ecall_q  <= 1'b0;
            mret_q   <= 1'b0;
            old_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid_i) begin
                funct3_q <= funct3_i;
                addr_q   <= csr_addr_i;
                src1_q   <= src1_i;
                zimm_q   <= zimm_i;
                rd_q     <= rd_i;
                pc_q     <= pc_i;
                ecall_q  <= is_ecall_i;
                mret_q   <= is_mret_i & ~is_ecall_i;
            end
            if (state_q == READ) old_q <= csr_rdata_i;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i) state_d = READ;
            READ:    state_d = WRITE;
            WRITE:   state_d = DONE;
            default: if (out_ready_i) state_d = IDLE;
        endcase
    end
    assign trap          = ecall_q | mret_q;
    assign in_ready_o    = state_q == IDLE;
    assign csr_addr_o    = in_ready_o ? 12'h000 : ecall_q ? CSR_MTVEC : mret_q ? CSR_MEPC : addr_q;
    // strobes are gated by rst_i so a reset landing on WRITE drops them that same cycle
    assign in_write      = state_q == WRITE && !rst_i;
    assign csr_we_o      = in_write && !trap && alu_we;
    assign csr_wdata_o   = csr_we_o ? alu_new : '0;
    assign trap_ecall_o  = in_write && ecall_q;
    assign trap_mret_o   = in_write && mret_q;
    assign mepc_o        = trap_ecall_o ? pc_q : '0;
    assign mcause_o      = trap_ecall_o ? XLEN'(ECALL_CAUSE) : '0;
    assign out_valid_o   = state_q == DONE;
    assign rd_o          = out_valid_o ? rd_q : 5'd0;
    assign rd_we_o       = out_valid_o && !trap && funct3_q[1:0] != 2'b00 && rd_q != 5'd0;
    assign rd_wdata_o    = out_valid_o && !trap ? old_q : '0;
    assign redirect_o    = out_valid_o && trap;
    assign redirect_pc_o = redirect_o ? old_q : '0;
endmodule

// File: tb/tb_csr_ctrl.sv
// tb_csr_ctrl: table-driven directed checks of the CSR sequencer against hand-computed results
module tb_csr_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_ready = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [11:0] csr_addr_in = '0, csr_addr;
    logic [31:0] src1 = '0, pc = '0, csr_rdata, csr_wdata, mepc, mcause, rd_wdata, redirect_pc;
    logic [4:0]  zimm = '0, rd = '0, rd_out;
    logic        is_ecall = 1'b0, is_mret = 1'b0;
    logic        csr_we, trap_ecall, trap_mret, out_valid, rd_we, redirect;
    logic [11:0] cur_raddr = 12'h000;
    logic [31:0] cur_old = '0;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] src1;
        logic [4:0]  zimm, rd;
        logic [31:0] pc;
        logic        ecall, mret;
        logic [11:0] raddr;
        logic [31:0] old;
        logic        we;
        logic [31:0] wdata;
        logic        t_ecall, t_mret, rd_we, redirect;
        int          hold;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;
    assign csr_rdata = (csr_addr == cur_raddr) ? cur_old : 32'hDEAD_BEEF;

    csr_ctrl #(.XLEN(32), .ECALL_CAUSE(11)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .funct3_i(funct3), .csr_addr_i(csr_addr_in), .src1_i(src1), .zimm_i(zimm),
        .rd_i(rd), .pc_i(pc), .is_ecall_i(is_ecall), .is_mret_i(is_mret),
        .csr_addr_o(csr_addr), .csr_rdata_i(csr_rdata), .csr_we_o(csr_we),
        .csr_wdata_o(csr_wdata), .trap_ecall_o(trap_ecall), .trap_mret_o(trap_mret),
        .mepc_o(mepc), .mcause_o(mcause), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .rd_o(rd_out), .rd_we_o(rd_we), .rd_wdata_o(rd_wdata), .redirect_o(redirect),
        .redirect_pc_o(redirect_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        funct3 = v.f3; csr_addr_in = v.addr; src1 = v.src1; zimm = v.zimm;
        rd = v.rd; pc = v.pc; is_ecall = v.ecall; is_mret = v.mret;
        cur_raddr = v.raddr; cur_old = v.old;
    endtask

    task automatic run(input int i, input vec_t v);
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        chk($sformatf("v%0d idle_ready", i), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("v%0d read_busy", i), 32'(in_ready), 32'd0);
        chk($sformatf("v%0d read_addr", i), 32'(csr_addr), 32'(v.raddr));
        chk($sformatf("v%0d read_quiet", i), 32'(csr_we | trap_ecall | trap_mret | out_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d write_we", i), 32'(csr_we), 32'(v.we));
        if (v.we) chk($sformatf("v%0d write_data", i), csr_wdata, v.wdata);
        chk($sformatf("v%0d write_addr", i), 32'(csr_addr), 32'(v.raddr));
        chk($sformatf("v%0d trap_ecall", i), 32'(trap_ecall), 32'(v.t_ecall));
        chk($sformatf("v%0d trap_mret", i), 32'(trap_mret), 32'(v.t_mret));
        chk($sformatf("v%0d write_valid", i), 32'(out_valid), 32'd0);
        if (v.t_ecall) begin
            chk($sformatf("v%0d mepc", i), mepc, v.pc);
            chk($sformatf("v%0d mcause", i), mcause, 32'd11);
        end
        @(negedge clk);
        in_valid = 1'b1;
        for (int c = 0; c <= v.hold; c++) begin
            chk($sformatf("v%0d done_valid c%0d", i, c), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d done_busy c%0d", i, c), 32'(in_ready), 32'd0);
            chk($sformatf("v%0d done_strobes c%0d", i, c), 32'(csr_we | trap_ecall | trap_mret), 32'd0);
            chk($sformatf("v%0d rd c%0d", i, c), 32'(rd_out), 32'(v.rd));
            chk($sformatf("v%0d rd_we c%0d", i, c), 32'(rd_we), 32'(v.rd_we));
            if (v.rd_we) chk($sformatf("v%0d rd_wdata c%0d", i, c), rd_wdata, v.old);
            chk($sformatf("v%0d redirect c%0d", i, c), 32'(redirect), 32'(v.redirect));
            if (v.redirect) chk($sformatf("v%0d redirect_pc c%0d", i, c), redirect_pc, v.old);
            if (c < v.hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("v%0d post_valid", i), 32'(out_valid), 32'd0);
        chk($sformatf("v%0d post_ready", i), 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        //          f3      addr     src1          zimm   rd     pc            ec    mr    raddr    old           we    wdata         te    tm    rdwe  redir hold
        vecs[0]  = '{3'b001, 12'h305, 32'h8000_0100, 5'd5,  5'd5, 32'h0,        1'b0, 1'b0, 12'h305, 32'h1234_5678, 1'b1, 32'h8000_0100, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[1]  = '{3'b010, 12'h300, 32'h0000_0008, 5'd1,  5'd3, 32'h0,        1'b0, 1'b0, 12'h300, 32'h0000_1800, 1'b1, 32'h0000_1808, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[2]  = '{3'b110, 12'h300, 32'h0,         5'd0,  5'd4, 32'h0,        1'b0, 1'b0, 12'h300, 32'h0000_1800, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[3]  = '{3'b011, 12'h342, 32'h0000_0003, 5'd2,  5'd0, 32'h0,        1'b0, 1'b0, 12'h342, 32'h0000_000B, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[4]  = '{3'b000, 12'h000, 32'h0,         5'd0,  5'd0, 32'h8000_0040, 1'b1, 1'b0, 12'h305, 32'h8000_0200, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 0};
        vecs[5]  = '{3'b000, 12'h000, 32'h0,         5'd0,  5'd0, 32'h0,        1'b0, 1'b1, 12'h341, 32'h8000_0044, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 5};
        vecs[6]  = '{3'b101, 12'h341, 32'hFFFF_FFFF, 5'h1F, 5'd7, 32'h0,        1'b0, 1'b0, 12'h341, 32'h0,         1'b1, 32'h0000_001F, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[7]  = '{3'b111, 12'h300, 32'h0,         5'h08, 5'd2, 32'h0,        1'b0, 1'b0, 12'h300, 32'h0000_1808, 1'b1, 32'h0000_1800, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[8]  = '{3'b100, 12'h300, 32'hFFFF_FFFF, 5'd3,  5'd1, 32'h0,        1'b0, 1'b0, 12'h300, 32'h0000_0055, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[9]  = '{3'b000, 12'h000, 32'h0,         5'd0,  5'd0, 32'h8000_0080, 1'b1, 1'b1, 12'h305, 32'h8000_0300, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 0};
        vecs[10] = '{3'b000, 12'h300, 32'h0000_00FF, 5'd6,  5'd9, 32'h0,        1'b0, 1'b0, 12'h300, 32'h0000_0077, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 0};

        repeat (2) @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset strobes", 32'(csr_we | trap_ecall | trap_mret), 32'd0);
        chk("reset csr_addr", 32'(csr_addr), 32'd0);
        chk("reset rd_we", 32'(rd_we | redirect), 32'd0);
        chk("reset redirect_pc", redirect_pc, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run(i, vecs[i]);

        // reset landing on WRITE must kill the strobe immediately and return to IDLE
        @(negedge clk);
        drive(vecs[0]);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rstw pre_we", 32'(csr_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstw we_dropped", 32'(csr_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rstw in_ready", 32'(in_ready), 32'd1);
        chk("rstw out_valid", 32'(out_valid), 32'd0);
        chk("rstw strobes", 32'(csr_we | trap_ecall | trap_mret), 32'd0);
        run(11, vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
